// File: rtl/pc_fetch_unit_pkg.sv
// ISA-level constants shared by the PIC16F fetch stage and its return stack.
package pc_fetch_unit_pkg;
    localparam int          ISA_PC_W        = 13;
    localparam int          ISA_STACK_DEPTH = 8;
    localparam logic [13:0] ISA_NOP_WORD    = 14'h0000;
    localparam logic [6:0]  ISA_PCL_ADDR    = 7'h02;
endpackage

// File: rtl/pc_fetch_unit_return_stack.sv
// Circular hardware return stack: pointer wraps on both overflow and underflow,
// with a saturating depth counter that only drives the error pulses.
module pc_fetch_unit_return_stack
    import pc_fetch_unit_pkg::*;
#(
    parameter int W     = ISA_PC_W,
    parameter int DEPTH = ISA_STACK_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic         overflow,
    output logic         underflow
);
    localparam int SP_W = $clog2(DEPTH);
    localparam logic [SP_W-1:0] SP_ONE    = SP_W'(1);
    localparam logic [SP_W:0]   DEPTH_ONE = (SP_W + 1)'(1);
    localparam logic [SP_W:0]   FULL      = (SP_W + 1)'(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp_reg;
    logic [SP_W:0]   depth_reg;
    logic [SP_W-1:0] sp_dec;
    logic            do_push;

    // A simultaneous push and pop is treated as a pure pop.
    assign do_push  = push & ~pop;
    assign sp_dec   = sp_reg - SP_ONE;
    assign pop_data = mem[sp_dec];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[sp_reg] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg    <= '0;
            depth_reg <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (pop) begin
                sp_reg <= sp_dec;
                if (depth_reg == '0)
                    underflow <= 1'b1;
                else
                    depth_reg <= depth_reg - DEPTH_ONE;
            end else if (do_push) begin
                sp_reg <= sp_reg + SP_ONE;
                if (depth_reg == FULL)
                    overflow <= 1'b1;
                else
                    depth_reg <= depth_reg + DEPTH_ONE;
            end
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// PIC16F program counter, return stack and instruction register, including the
// computed-goto flush that follows a register-file write to PCL.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int          PC_W        = ISA_PC_W,
    parameter int          STACK_DEPTH = ISA_STACK_DEPTH,
    parameter logic [13:0] NOP_WORD    = ISA_NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_incr_en,
    input  logic            pc_j_en,
    input  logic            pc_j_and_push_en,
    input  logic            pc_j_by_pop_en,
    input  logic            instr_rd_en,
    input  logic            instr_flush,
    input  logic [4:0]      pclath,
    input  logic            pcl_wr_en,
    input  logic [7:0]      pcl_wr_data,
    output logic [PC_W-1:0] prog_addr,
    input  logic [13:0]     prog_data,
    output logic [13:0]     instr_current,
    output logic [7:0]      pcl,
    output logic            stack_overflow,
    output logic            stack_underflow
);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [13:0]     ir_reg;
    logic            flush_pending_reg;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] pop_data;
    logic            pending_hit;
    logic            eff_flush;
    logic            push;

    assign jump_target = {pclath[4:3], instr_current[10:0]};
    // The first fetch after a PCL write is stale, so it becomes a NOP and the PC holds.
    assign pending_hit = instr_rd_en & flush_pending_reg;
    assign eff_flush   = instr_flush | pending_hit;
    assign push        = pc_j_and_push_en & ~pc_j_by_pop_en;

    pc_fetch_unit_return_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pc_j_by_pop_en),
        .push_data (pc_reg),
        .pop_data  (pop_data),
        .overflow  (stack_overflow),
        .underflow (stack_underflow)
    );

    always_comb begin
        pc_next = pc_reg;
        if (pc_j_by_pop_en)
            pc_next = pop_data;
        else if (pc_j_and_push_en || pc_j_en)
            pc_next = jump_target;
        else if (pcl_wr_en)
            pc_next = {pclath, pcl_wr_data};
        else if (pc_incr_en && !pending_hit)
            pc_next = pc_reg + PC_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg            <= '0;
            ir_reg            <= NOP_WORD;
            flush_pending_reg <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            if (eff_flush)
                ir_reg <= NOP_WORD;
            else if (instr_rd_en)
                ir_reg <= prog_data;
            if (pcl_wr_en)
                flush_pending_reg <= 1'b1;
            else if (instr_rd_en)
                flush_pending_reg <= 1'b0;
        end
    end

    assign prog_addr     = pc_reg;
    assign pcl           = pc_reg[7:0];
    assign instr_current = ir_reg;
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program counter, 8-level hardware return stack and instruction register for the PIC16F core. It sits directly upstream of the instruction decoder and produces instr_current. It consumes the decoder's one-cycle strobes (pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en, instr_rd_en, instr_flush), which are issued on q_count==3. It also handles computed gotos (register-file writes to PCL) with an automatic pipeline flush.

Parameters:
PC_W, 13, program counter width (8K words)
STACK_DEPTH, 8, return stack entries (power of two)
NOP_WORD, 14'h0000, word loaded into the instruction register on flush/reset

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
pc_incr_en  in  1  PC <= PC+1
pc_j_en  in  1  goto: PC <= jump target
pc_j_and_push_en  in  1  call: push PC, PC <= jump target
pc_j_by_pop_en  in  1  return: PC <= popped value
instr_rd_en  in  1  load instruction register from prog_data
instr_flush  in  1  load instruction register with NOP_WORD
pclath  in  5  PCLATH register value
pcl_wr_en  in  1  register file is writing PCL (address 0x02) this cycle
pcl_wr_data  in  8  data written to PCL
prog_addr  out  13  program memory address (= PC, combinational)
prog_data  in  14  program memory read data (combinational read of prog_addr)
instr_current  out  14  instruction register, to decoder
pcl  out  8  PC[7:0], for register-file reads of PCL
stack_overflow  out  1  one-cycle pulse: push at full depth
stack_underflow  out  1  one-cycle pulse: pop at zero depth

Behaviour:
- Interface: one clock (clk). rst is asynchronous, active-high.
- Reset values: PC=0, instr_current=NOP_WORD, stack pointer=0, depth=0, flush_pending=0, both flags=0. Stack contents are not reset.
- PC semantics: PC is always the address of the next word to fetch. Fetch is in-cycle: on an instr_rd_en edge, instr_current <= prog_data (the word at the pre-update PC).
- Jump target: {pclath[4:3], instr_current[10:0]}.
- PC update priority (highest first; exactly one applies per edge):
  1. pc_j_by_pop_en
  2. pc_j_and_push_en
  3. pc_j_en
  4. pcl_wr_en: PC <= {pclath, pcl_wr_data}
  5. pc_incr_en, unless suppressed
  6. hold
- Increment wraps modulo 2^13: 0x1FFF -> 0x0000.
- Instruction register priority: effective flush > instr_rd_en > hold.
  - Effective flush = instr_flush OR (instr_rd_en AND flush_pending).
- Computed goto: pcl_wr_en sets flush_pending (decoder writes on q2).
  - The next instr_rd_en is converted to a flush, and pc_incr_en is suppressed on that same edge. flush_pending then clears.
  - pcl_wr_en and pc_j_* in the same cycle: the jump wins and flush_pending is still set.
- Push: stack[sp] <= PC (already the return address, call+1); sp <= sp+1 (mod 8).
  - depth <= min(depth+1, 8).
  - Push at depth 8: pulse stack_overflow; the oldest entry is overwritten via circular wrap.
- Pop: PC <= stack[sp-1]; sp <= sp-1 (mod 8).
  - depth <= max(depth-1, 0).
  - Pop at depth 0: pulse stack_underflow; the pointer still wraps and the stale entry is used.
- Push and pop asserted together: pop only; no stack write.
- Reset mid-instruction: immediate asynchronous return to reset values; any in-flight strobe is ignored.

Decomposition:
- Shared package (isa constants header): NOP_WORD, PCL address 0x02, PC_W, STACK_DEPTH.
- One sub-module: return_stack (8x13 storage, sp, depth, overflow/underflow), with push/pop/data ports.
- PC mux, instruction register and flush_pending stay in pc_fetch_unit.

Test Plan:
- Reset then three pc_incr_en+instr_rd_en strobes with prog = {0:0x3005, 1:0x0000, 2:0x2803} -> instr_current sequence 0x3005, 0x0000, 0x2803; PC=3.
- Goto: instr_current=0x2ABC, pclath=5'b11000, pc_j_en+instr_flush -> PC=0x1ABC; instr_current=0x0000.
- Call at PC=0x0123 (call word fetched from 0x0122), pclath=0, instr_current=0x2050 -> stack top=0x0123, PC=0x0050. Then pc_j_by_pop_en+flush -> PC=0x0123, depth=0.
- Nine nested calls -> stack_overflow pulses on the 9th. Nine returns -> first eight return values are in reverse order, with the entry-0 value replaced by the 9th push. stack_underflow pulses on the 9th return.
- Computed goto: pcl_wr_en with data=0x40, pclath=0x02 -> PC=0x0240. Next pc_incr_en+instr_rd_en -> instr_current=0x0000, PC stays 0x0240. The following fetch loads prog[0x240].
- Skip (flush+incr) at PC=0x0010 -> instr_current=0x0000, PC=0x0011. Also PC=0x1FFF with incr -> 0x0000. Also rst asserted between edges -> outputs reset immediately, without waiting for clk.
